alu_operand_datapath: RTL and testbench

- Execute-stage datapath slice for the 32-bit CPU core.
- Contains three sub-functions:
  - a 2:1 A-operand mux (register or PC);
  - a 4:1 B-operand mux (register, sign-extended imm16, sign-extended imm22, constant 1);
  - a 4-bit-opcode ALU.
- The combinational result feeds branch target, PC increment and load/store address logic.
- A registered copy of the result and zero flag is provided for the next pipeline step.

---
 rtl/alu_operand_datapath.sv | 108 ++++++++++
 tb/tb_alu_operand_datapath.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_datapath.sv
// alu_operand_datapath
// Execute-stage datapath slice: A/B operand muxes, a 4-bit-opcode ALU and a
// registered copy of the result and zero flag for the next pipeline step.
// The mux and ALU path is purely combinational and ignores rst.
module alu_operand_datapath #(
    parameter int DWIDTH  = 32,
    parameter int PCWIDTH = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_sel,
    input  logic [1:0]        b_sel,
    input  logic [3:0]        aluop,
    input  logic [DWIDTH-1:0] reg_a,
    input  logic [DWIDTH-1:0] reg_b,
    input  logic [PCWIDTH-1:0] pc,
    input  logic [15:0]       imm16,
    input  logic [21:0]       imm22,
    input  logic              en,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    output logic [DWIDTH-1:0] res,
    output logic              zero,
    output logic [DWIDTH-1:0] res_q,
    output logic              zero_q
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SAR  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_NOR  = 4'd10,
        OP_PASB = 4'd11,
        OP_PASA = 4'd12
    } aluop_e;

    logic [DWIDTH-1:0] res_d;
    logic              zero_d;
    logic [4:0]        shamt;

    // Only the low five bits of B steer the shifter.
    assign shamt = alu_b[4:0];

    // A operand: register data or the word PC, zero-extended.
    always_comb begin
        alu_a = reg_a;
        if (a_sel) begin
            alu_a = DWIDTH'(pc);
        end
    end

    // B operand: register, sign-extended immediates, or the constant 1.
    always_comb begin
        // NOTE: every combinationally driven signal gets a default first so no path can infer a latch.
        alu_b = reg_b;
        case (b_sel)
            2'b00:   alu_b = reg_b;
            2'b01:   alu_b = DWIDTH'($signed(imm16));
            2'b10:   alu_b = DWIDTH'($signed(imm22));
            default: alu_b = DWIDTH'(1);
        endcase
    end

    // ALU: modulo-2^DWIDTH arithmetic, logic, shifts and compares; spare opcodes yield 0.
    always_comb begin
        res_d = '0;
        case (aluop_e'(aluop))
            OP_ADD:  res_d = alu_a + alu_b;
            OP_SUB:  res_d = alu_a - alu_b;
            OP_AND:  res_d = alu_a & alu_b;
            OP_OR:   res_d = alu_a | alu_b;
            OP_XOR:  res_d = alu_a ^ alu_b;
            OP_SHL:  res_d = alu_a << shamt;
            OP_SHR:  res_d = alu_a >> shamt;
            OP_SAR:  res_d = DWIDTH'($signed(alu_a) >>> shamt);
            OP_SLT:  res_d = DWIDTH'($signed(alu_a) < $signed(alu_b));
            OP_SLTU: res_d = DWIDTH'(alu_a < alu_b);
            OP_NOR:  res_d = ~(alu_a | alu_b);
            OP_PASB: res_d = alu_b;
            OP_PASA: res_d = alu_a;
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
    end

    assign res  = res_d;
    assign zero = zero_d;

    // Result register: capture on en; reset forces a clean "zero result" state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            res_q  <= '0;
            zero_q <= 1'b1;
        end else if (en) begin
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_datapath.sv
// Scoreboard bench for alu_operand_datapath: the driver pushes the expected
// combinational response for every applied vector, a negedge monitor pops and
// compares it, and a reference register model tracks res_q/zero_q.
module tb_alu_operand_datapath;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        a_sel = 1'b0;
    logic [1:0]  b_sel = 2'b00;
    logic [3:0]  aluop = 4'd0;
    logic [31:0] reg_a = 32'd0;
    logic [31:0] reg_b = 32'd0;
    logic [29:0] pc    = 30'd0;
    logic [15:0] imm16 = 16'd0;
    logic [21:0] imm22 = 22'd0;
    logic        en    = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] res;
    logic        zero;
    logic [31:0] res_q;
    logic        zero_q;

    alu_operand_datapath #(.DWIDTH(32), .PCWIDTH(30)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_sel  (a_sel),
        .b_sel  (b_sel),
        .aluop  (aluop),
        .reg_a  (reg_a),
        .reg_b  (reg_b),
        .pc     (pc),
        .imm16  (imm16),
        .imm22  (imm22),
        .en     (en),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .res    (res),
        .zero   (zero),
        .res_q  (res_q),
        .zero_q (zero_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_q  = 32'd0;
    logic        m_zq = 1'b1;

    // Reference model: the operation table computed with plain arithmetic.
    function automatic exp_t model(input logic asel, input logic [1:0] bsel,
                                   input logic [3:0] op, input logic [31:0] ra,
                                   input logic [31:0] rb, input logic [29:0] p,
                                   input logic [15:0] i16, input logic [21:0] i22);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          sh;
        a = asel ? {2'b00, p} : ra;
        case (bsel)
            2'd0:    b = rb;
            2'd1:    b = i16[15] ? (32'hFFFF0000 | 32'(i16)) : 32'(i16);
            2'd2:    b = i22[21] ? (32'hFFC00000 | 32'(i22)) : 32'(i22);
            default: b = 32'd1;
        endcase
        sh = int'(b % 32);
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = a >> sh;
            4'd7:    r = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            4'd8:    r = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
            4'd9:    r = (a < b) ? 32'd1 : 32'd0;
            4'd10:   r = ~(a | b);
            4'd11:   r = b;
            4'd12:   r = a;
            default: r = 32'd0;
        endcase
        e.a   = a;
        e.b   = b;
        e.res = r;
        e.z   = (r == 32'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always_comb cur = model(a_sel, b_sel, aluop, reg_a, reg_b, pc, imm16, imm22);

    // Reference result register.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q  <= 32'd0;
            m_zq <= 1'b1;
        end else if (en) begin
            m_q  <= cur.res;
            m_zq <= cur.z;
        end
    end

    // Apply one vector just after a rising edge and log its expected response.
    task automatic apply(input logic asel, input logic [1:0] bsel, input logic [3:0] op,
                         input logic [31:0] ra, input logic [31:0] rb, input logic [29:0] p,
                         input logic [15:0] i16, input logic [21:0] i22, input logic e);
        @(posedge clk);
        #2;
        a_sel = asel;
        b_sel = bsel;
        aluop = op;
        reg_a = ra;
        reg_b = rb;
        pc    = p;
        imm16 = i16;
        imm22 = i22;
        en    = e;
        exp_q.push_back(model(asel, bsel, op, ra, rb, p, i16, i22));
    endtask

    // Monitor: compare outputs on the falling edge against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("alu_a", alu_a, e.a);
                check("alu_b", alu_b, e.b);
                check("res", res, e.res);
                check("zero", 32'(zero), 32'(e.z));
            end
            check("res_q", res_q, m_q);
            check("zero_q", 32'(zero_q), 32'(m_zq));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        // Hold reset for a couple of edges, then release between edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset_res_q", res_q, 32'd0);
        check("reset_zero_q", 32'(zero_q), 32'd1);
        #1;
        rst = 1'b0;

        // PC increment and its capture.
        apply(1'b1, 2'b11, 4'd0, 32'd0, 32'd0, 30'h3FFFFFFF, 16'd0, 22'd0, 1'b1);
        apply(1'b0, 2'b00, 4'd12, 32'd7, 32'd0, 30'd0, 16'd0, 22'd0, 1'b0);
        check("pc_inc_res_q", res_q, 32'h40000000);

        // Immediate sign extension.
        apply(1'b0, 2'b01, 4'd0, 32'd0, 32'd0, 30'd0, 16'h8000, 22'd0, 1'b0);
        apply(1'b0, 2'b01, 4'd0, 32'd0, 32'd0, 30'd0, 16'h7FFF, 22'd0, 1'b0);
        apply(1'b0, 2'b10, 4'd0, 32'd0, 32'd0, 30'd0, 16'd0, 22'h200000, 1'b0);
        apply(1'b0, 2'b10, 4'd0, 32'd0, 32'd0, 30'd0, 16'd0, 22'h1FFFFF, 1'b0);

        // Arithmetic and compares.
        apply(1'b0, 2'b00, 4'd1, 32'd0, 32'd1, 30'd0, 16'd0, 22'd0, 1'b0);
        apply(1'b0, 2'b00, 4'd1, 32'd5, 32'd5, 30'd0, 16'd0, 22'd0, 1'b1);
        apply(1'b0, 2'b00, 4'd8, 32'hFFFFFFFF, 32'd1, 30'd0, 16'd0, 22'd0, 1'b0);
        check("zero_capture", 32'(zero_q), 32'd1);
        apply(1'b0, 2'b00, 4'd9, 32'hFFFFFFFF, 32'd1, 30'd0, 16'd0, 22'd0, 1'b0);

        // Shifts with an amount whose upper bits must be ignored.
        apply(1'b0, 2'b00, 4'd6, 32'h80000000, 32'h24, 30'd0, 16'd0, 22'd0, 1'b0);
        apply(1'b0, 2'b00, 4'd7, 32'h80000000, 32'h24, 30'd0, 16'd0, 22'd0, 1'b0);
        apply(1'b0, 2'b00, 4'd5, 32'h80000000, 32'h24, 30'd0, 16'd0, 22'd0, 1'b0);

        // Logic, pass-through and spare opcodes.
        for (int op = 2; op <= 15; op++) begin
            if (op < 5 || op > 9) begin
                apply(1'b0, 2'b00, 4'(op), 32'hF0F0F0F0, 32'h0FF00FF0, 30'd0, 16'd0, 22'd0, 1'b0);
            end
        end

        // Register hold: load 0x1234, then three edges with en low while res moves.
        apply(1'b0, 2'b00, 4'd12, 32'h1234, 32'd0, 30'd0, 16'd0, 22'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'b00, 4'd0, $urandom, $urandom, 30'd0, 16'd0, 22'd0, 1'b0);
        end
        @(posedge clk);
        #1;
        check("hold_res_q", res_q, 32'h1234);

        // Reset between edges discards a pending capture and dominates en.
        apply(1'b0, 2'b00, 4'd12, 32'hABCD, 32'd0, 30'd0, 16'd0, 22'd0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_res_q", res_q, 32'd0);
        check("async_rst_zero_q", 32'(zero_q), 32'd1);
        @(posedge clk);
        #1;
        check("rst_dominates_en", res_q, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_capture_after_rst", res_q, 32'hABCD);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  $urandom, (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom),
                  30'($urandom), 16'($urandom), 22'($urandom), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
